// File: rtl/btn_mode_pkg.sv
// Shared definitions for the stopwatch front-panel mode controller:
// mode encoding, button bit positions and counter sizing.
package btn_mode_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ADJ   = 2'd3
  } state_t;

  localparam int BTN_PAUSE  = 0;
  localparam int BTN_RESET  = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_ADJUST = 3;

  // Edge history after reset: every button looks "already pressed", so a
  // button held through reset has to be released before it can act.
  localparam logic [3:0] BTN_HIST_INIT = 4'b1111;

  // Width of a saturating counter that must reach the value p.
  function automatic int cnt_width(input int p);
    return $clog2(p) + 1;
  endfunction

endpackage

// File: rtl/btn_hold_repeat.sv
// Auto-repeat pulse generator for a held button. A start request emits the
// first pulse; while the level stays high and the block is enabled, the next
// pulse follows REPEAT_DELAY cycles later and then every REPEAT_RATE cycles.
// Dropping the level or the enable kills the sequence immediately.
module btn_hold_repeat
  import btn_mode_pkg::*;
#(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic clk1KHz,
  input  logic rst_n,
  input  logic lvl,
  input  logic en,
  input  logic start,
  output logic inc
);

  localparam int CW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

  logic [CW-1:0] cnt_r;
  logic          active_r;
  logic          first_r;
  logic          inc_r;
  logic          hit_s;

  // Interval expiry: the first gap is the long delay, later gaps the rate.
  always_comb begin
    hit_s = 1'b0;
    if (active_r) begin
      if (first_r) begin
        hit_s = (cnt_r == CW'(REPEAT_DELAY - 1));
      end else begin
        hit_s = (cnt_r == CW'(REPEAT_RATE - 1));
      end
    end else begin
      hit_s = 1'b0;
    end
  end

  // Repeat sequencer: restart on a new press, pulse on expiry, clear on release.
  always_ff @(posedge clk1KHz) begin
    if (!rst_n) begin
      cnt_r    <= {CW{1'b0}};
      active_r <= 1'b0;
      first_r  <= 1'b0;
      inc_r    <= 1'b0;
    end else if (!en || !lvl) begin
      cnt_r    <= {CW{1'b0}};
      active_r <= 1'b0;
      first_r  <= 1'b0;
      inc_r    <= 1'b0;
    end else if (start) begin
      cnt_r    <= {CW{1'b0}};
      active_r <= 1'b1;
      first_r  <= 1'b1;
      inc_r    <= 1'b1;
    end else if (hit_s) begin
      cnt_r    <= {CW{1'b0}};
      first_r  <= 1'b0;
      inc_r    <= 1'b1;
    end else begin
      inc_r <= 1'b0;
      if (active_r && (cnt_r != {CW{1'b1}})) begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign inc = inc_r;

endmodule

// File: rtl/btn_mode_ctrl.sv
// Stopwatch front-panel mode controller (STOP / RUN / PAUSE / ADJ).
// Detects button press edges, arbitrates same-cycle presses by fixed priority
// (reset > pause > select > adjust), drives the counter enable, clear pulse,
// adjust field select, adjust increments (with auto-repeat) and blink.
// Optional build macro BTN_MODE_CTRL_ADJ_TIMEOUT_EN: leave ADJ for PAUSE after
// ADJ_TIMEOUT idle cycles.
module btn_mode_ctrl
  import btn_mode_pkg::*;
#(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int BLINK_PERIOD = 250,
  parameter int ADJ_TIMEOUT  = 5000
) (
  input  logic       clk1KHz,
  input  logic       rst_n,
  input  logic [3:0] btn_lvl,
  output logic       run,
  output logic       clr,
  output logic       adj_mode,
  output logic       adj_sel,
  output logic       adj_inc,
  output logic       blink
);

  localparam int BW = cnt_width(BLINK_PERIOD);

  state_t        state_r, state_nx_s;
  logic [3:0]    prev_r;
  logic [3:0]    ev_s;
  logic          clr_s, sel_nx_s, start_s, timeout_s;
  logic          run_r, clr_r, adj_mode_r, adj_sel_r, blink_r;
  logic          run_nx_s, adj_mode_nx_s, blink_nx_s;
  logic [BW-1:0] blink_cnt_r, blink_cnt_nx_s;
  logic          adj_inc_s;

  assign ev_s = btn_lvl & ~prev_r;

  // State register and button edge history.
  always_ff @(posedge clk1KHz) begin
    if (!rst_n) begin
      state_r <= STOP;
      prev_r  <= BTN_HIST_INIT;
    end else begin
      state_r <= state_nx_s;
      prev_r  <= btn_lvl;
    end
  end

`ifdef BTN_MODE_CTRL_ADJ_TIMEOUT_EN
  localparam int TW = cnt_width(ADJ_TIMEOUT);
  logic [TW-1:0] idle_cnt_r;

  assign timeout_s = (idle_cnt_r == TW'(ADJ_TIMEOUT));

  // Inactivity counter: runs only while staying in ADJ, any activity restarts it.
  always_ff @(posedge clk1KHz) begin
    if (!rst_n) begin
      idle_cnt_r <= {TW{1'b0}};
    end else if ((state_r != ADJ) || (state_nx_s != ADJ) || (ev_s != 4'b0000) || adj_inc_s) begin
      idle_cnt_r <= {TW{1'b0}};
    end else if (idle_cnt_r != {TW{1'b1}}) begin
      idle_cnt_r <= idle_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end
`else
  logic unused_timeout_s;
  assign timeout_s        = 1'b0;
  assign unused_timeout_s = (ADJ_TIMEOUT > 32'sd0);
`endif

  // Next state: the highest-priority press that is meaningful in this mode wins.
  always_comb begin
    state_nx_s = state_r;
    clr_s      = 1'b0;
    sel_nx_s   = adj_sel_r;
    start_s    = 1'b0;
    case (state_r)
      STOP: begin
        if (ev_s[BTN_RESET]) begin
          clr_s = 1'b1;
        end else if (ev_s[BTN_PAUSE]) begin
          state_nx_s = RUN;
        end else if (ev_s[BTN_SELECT]) begin
          state_nx_s = ADJ;
          sel_nx_s   = 1'b0;
        end else begin
          state_nx_s = STOP;
        end
      end
      RUN: begin
        if (ev_s[BTN_RESET]) begin
          state_nx_s = STOP;
          clr_s      = 1'b1;
        end else if (ev_s[BTN_PAUSE]) begin
          state_nx_s = PAUSE;
        end else begin
          state_nx_s = RUN;
        end
      end
      PAUSE: begin
        if (ev_s[BTN_RESET]) begin
          state_nx_s = STOP;
          clr_s      = 1'b1;
        end else if (ev_s[BTN_PAUSE]) begin
          state_nx_s = RUN;
        end else if (ev_s[BTN_SELECT]) begin
          state_nx_s = ADJ;
          sel_nx_s   = 1'b0;
        end else begin
          state_nx_s = PAUSE;
        end
      end
      ADJ: begin
        if (ev_s[BTN_RESET]) begin
          state_nx_s = STOP;
          clr_s      = 1'b1;
          sel_nx_s   = 1'b0;
        end else if (ev_s[BTN_PAUSE]) begin
          state_nx_s = PAUSE;
        end else if (ev_s[BTN_SELECT]) begin
          sel_nx_s = ~adj_sel_r;
        end else if (ev_s[BTN_ADJUST]) begin
          start_s = 1'b1;
        end else if (timeout_s) begin
          state_nx_s = PAUSE;
        end else begin
          state_nx_s = ADJ;
        end
      end
      default: begin
        state_nx_s = STOP;
      end
    endcase
  end

  // Output decode and blink timing; blink restarts from 0 on every ADJ entry.
  always_comb begin
    run_nx_s       = (state_nx_s == RUN);
    adj_mode_nx_s  = (state_nx_s == ADJ);
    blink_nx_s     = blink_r;
    blink_cnt_nx_s = blink_cnt_r;
    if ((state_nx_s != ADJ) || (state_r != ADJ)) begin
      blink_nx_s     = 1'b0;
      blink_cnt_nx_s = {BW{1'b0}};
    end else if (blink_cnt_r == BW'(BLINK_PERIOD - 1)) begin
      blink_nx_s     = ~blink_r;
      blink_cnt_nx_s = {BW{1'b0}};
    end else if (blink_cnt_r != {BW{1'b1}}) begin
      blink_cnt_nx_s = blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
    end else begin
      blink_cnt_nx_s = blink_cnt_r;
    end
  end

  // Output registers.
  always_ff @(posedge clk1KHz) begin
    if (!rst_n) begin
      run_r       <= 1'b0;
      clr_r       <= 1'b0;
      adj_mode_r  <= 1'b0;
      adj_sel_r   <= 1'b0;
      blink_r     <= 1'b0;
      blink_cnt_r <= {BW{1'b0}};
    end else begin
      run_r       <= run_nx_s;
      clr_r       <= clr_s;
      adj_mode_r  <= adj_mode_nx_s;
      adj_sel_r   <= sel_nx_s;
      blink_r     <= blink_nx_s;
      blink_cnt_r <= blink_cnt_nx_s;
    end
  end

  btn_hold_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_hold_repeat (
    .clk1KHz (clk1KHz),
    .rst_n   (rst_n),
    .lvl     (btn_lvl[BTN_ADJUST]),
    .en      (state_nx_s == ADJ),
    .start   (start_s),
    .inc     (adj_inc_s)
  );

  assign run      = run_r;
  assign clr      = clr_r;
  assign adj_mode = adj_mode_r;
  assign adj_sel  = adj_sel_r;
  assign adj_inc  = adj_inc_s;
  assign blink    = blink_r;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Scoreboard bench for btn_mode_ctrl: each stimulus cycle runs a rule-level
// reference model and queues the expected outputs; a monitor pops and compares
// on the falling edge.
module tb_btn_mode_ctrl;

  localparam int RD = 500;
  localparam int RR = 100;
  localparam int BP = 250;

  localparam int M_STOP  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ADJ   = 3;

  typedef struct packed {
    logic run;
    logic clr;
    logic adj_mode;
    logic adj_sel;
    logic adj_inc;
    logic blink;
  } exp_t;

  logic       clk1KHz = 1'b0;
  logic       rst_n   = 1'b0;
  logic [3:0] btn_lvl = 4'b0000;
  logic       run, clr, adj_mode, adj_sel, adj_inc, blink;

  always #5 clk1KHz = ~clk1KHz;

  btn_mode_ctrl #(
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR),
    .BLINK_PERIOD (BP),
    .ADJ_TIMEOUT  (5000)
  ) dut (
    .clk1KHz  (clk1KHz),
    .rst_n    (rst_n),
    .btn_lvl  (btn_lvl),
    .run      (run),
    .clr      (clr),
    .adj_mode (adj_mode),
    .adj_sel  (adj_sel),
    .adj_inc  (adj_inc),
    .blink    (blink)
  );

  // Which buttons mean something in each mode: [mode][pause,reset,select,adjust].
  bit valid_tbl [4][4] = '{'{1'b1, 1'b1, 1'b1, 1'b0},
                           '{1'b1, 1'b1, 1'b0, 1'b0},
                           '{1'b1, 1'b1, 1'b1, 1'b0},
                           '{1'b1, 1'b1, 1'b1, 1'b1}};
  int prio [4] = '{1, 0, 2, 3};

  int         m_mode  = M_STOP;
  logic [3:0] m_prev  = 4'b1111;
  bit         m_sel   = 1'b0;
  bit         m_alive = 1'b0;
  int         m_press = 0;
  int         m_entry = 0;
  int         m_n     = 0;

  exp_t exp_q [$];
  int   cyc_q [$];
  exp_t mon_e;
  int   mon_c;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: one sampling edge with inputs b / r.
  task automatic model_step(input logic [3:0] b, input logic r, output exp_t e);
    logic [3:0] ev;
    int won;
    int d;
    e = '0;
    if (!r) begin
      m_mode  = M_STOP;
      m_prev  = 4'b1111;
      m_sel   = 1'b0;
      m_alive = 1'b0;
    end else begin
      ev     = b & ~m_prev;
      m_prev = b;
      won    = -1;
      for (int k = 0; k < 4; k++) begin
        if (won < 0 && ev[prio[k]] && valid_tbl[m_mode][prio[k]]) won = prio[k];
      end
      case (won)
        1: begin
          if (m_mode == M_ADJ) m_sel = 1'b0;
          m_mode = M_STOP;
          e.clr  = 1'b1;
        end
        0: m_mode = (m_mode == M_RUN || m_mode == M_ADJ) ? M_PAUSE : M_RUN;
        2: begin
          if (m_mode == M_ADJ) m_sel = ~m_sel;
          else begin
            m_mode  = M_ADJ;
            m_sel   = 1'b0;
            m_entry = m_n;
          end
        end
        3: begin
          m_alive = 1'b1;
          m_press = m_n;
        end
        default: ;
      endcase
      if (m_mode != M_ADJ || !b[3]) m_alive = 1'b0;
      if (m_alive) begin
        d = m_n - m_press;
        e.adj_inc = (d == 0) || (d >= RD && ((d - RD) % RR) == 0);
      end
      e.blink = (m_mode == M_ADJ) && (((m_n - m_entry) / BP) % 2 == 1);
    end
    e.run      = (m_mode == M_RUN);
    e.adj_mode = (m_mode == M_ADJ);
    e.adj_sel  = m_sel;
    m_n++;
  endtask

  task automatic step(input logic [3:0] b, input logic r);
    exp_t e;
    btn_lvl = b;
    rst_n   = r;
    model_step(b, r, e);
    exp_q.push_back(e);
    cyc_q.push_back(m_n - 1);
    @(posedge clk1KHz);
    #1;
  endtask

  task automatic hold(input logic [3:0] b, input logic r, input int len);
    for (int i = 0; i < len; i++) step(b, r);
  endtask

  // Monitor: compare the registered outputs against the queued expectation.
  always @(negedge clk1KHz) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_c = cyc_q.pop_front();
      n_checks++;
      if ({run, clr, adj_mode, adj_sel, adj_inc, blink} === mon_e) begin
        n_pass++;
      end else begin
        $display("FAIL outputs edge %0d: run/clr/adj_mode/adj_sel/adj_inc/blink actual %b required %b",
                 mon_c, {run, clr, adj_mode, adj_sel, adj_inc, blink}, mon_e);
      end
    end
  end

  initial begin
    logic [3:0] b;
    int r;
    // Reset with pause held, release reset while still held.
    hold(4'b0001, 1'b0, 3);
    hold(4'b0001, 1'b1, 10);
    hold(4'b0000, 1'b1, 3);
    // Run / pause / run / clear.
    hold(4'b0001, 1'b1, 3); hold(4'b0000, 1'b1, 3);
    hold(4'b0001, 1'b1, 2); hold(4'b0000, 1'b1, 2);
    hold(4'b0001, 1'b1, 2); hold(4'b0000, 1'b1, 2);
    hold(4'b0010, 1'b1, 2); hold(4'b0000, 1'b1, 3);
    // Simultaneous pause + reset while running.
    hold(4'b0001, 1'b1, 2); hold(4'b0000, 1'b1, 2);
    hold(4'b0011, 1'b1, 2); hold(4'b0000, 1'b1, 3);
    // Enter ADJ, hold adjust for auto-repeat, release.
    hold(4'b0100, 1'b1, 2); hold(4'b0000, 1'b1, 2);
    hold(4'b1000, 1'b1, 1000);
    hold(4'b0000, 1'b1, 200);
    // Toggle field select, then leave via pause.
    hold(4'b0100, 1'b1, 2); hold(4'b0000, 1'b1, 2);
    hold(4'b0001, 1'b1, 2); hold(4'b0000, 1'b1, 5);
    // Re-enter ADJ and reset mid-repeat.
    hold(4'b0100, 1'b1, 2); hold(4'b0000, 1'b1, 2);
    hold(4'b1000, 1'b1, 550);
    hold(4'b1000, 1'b0, 1);
    hold(4'b0000, 1'b1, 5);
    // Randomized segments.
    for (int s = 0; s < 80; s++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        hold(4'($urandom_range(0, 15)), 1'b0, $urandom_range(1, 3));
      end else begin
        for (int i = 0; i < 4; i++) b[i] = ($urandom_range(0, 3) == 0);
        hold(b, 1'b1, (r < 20) ? $urandom_range(300, 700) : $urandom_range(1, 40));
      end
    end
    @(negedge clk1KHz);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: actual %0d pending expectations, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
